// File: rtl/serial_add_display_ctrl.sv
// serial_add_display_ctrl
// Two-requester, round-robin arbitrated 6-bit adder built on one shared 1-bit
// full adder. The 7-bit result is converted to BCD by double-dabble and shown
// on three active-low 7-segment digits (hundreds, tens, units).
module serial_add_display_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [5:0] a0,
   input  logic [5:0] b0,
   input  logic       req1,
   input  logic [5:0] a1,
   input  logic [5:0] b1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       busy,
   output logic       done,
   output logic [6:0] sum,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      CONV = 2'd2,
      SHOW = 2'd3
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low segment pattern, {g,f,e,d,c,b,a}
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Double-dabble correction: add 3 to a digit of 5 or more before shifting
   function automatic logic [3:0] dd_adj(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   state_t      state_q;
   logic        rr_q;        // 1: requester 1 wins a tie
   logic [5:0]  opa_q;       // operand A, sum bits shift in from the top
   logic [5:0]  opb_q;
   logic        carry_q;
   logic [2:0]  cnt_q;
   logic [6:0]  res_q;       // completed sum awaiting display
   logic [6:0]  bin_q;       // binary side of the double-dabble shifter
   logic [11:0] bcd_q;       // {hundreds, tens, units}
   logic        gnt0_q;
   logic        gnt1_q;
   logic        done_q;
   logic [6:0]  sum_q;
   logic [6:0]  hex0_q;
   logic [6:0]  hex1_q;
   logic [6:0]  hex2_q;

   logic        fa_s;
   logic        fa_co;
   logic        pick0;
   logic        pick1;
   logic [11:0] bcd_shift;

   // Shared 1-bit full adder on the current LSBs
   always_comb begin
      fa_s  = opa_q[0] ^ opb_q[0] ^ carry_q;
      fa_co = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
   end

   // Round-robin pick: a lone request always wins, a tie goes to rr_q
   always_comb begin
      pick1 = req1 & (~req0 | rr_q);
      pick0 = req0 & ~pick1;
   end

   // One double-dabble step; hundreds never exceeds 1 for a 7-bit input,
   // so only tens and units need correction
   always_comb begin
      bcd_shift = {bcd_q[10:8], dd_adj(bcd_q[7:4]), dd_adj(bcd_q[3:0]), bin_q[6]};
   end

   // Control FSM with registered grant/done/display outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         hex0_q  <= SEG_BLANK;
         hex1_q  <= SEG_BLANK;
         hex2_q  <= SEG_BLANK;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick0 | pick1) begin
                  opa_q   <= pick1 ? a1 : a0;
                  opb_q   <= pick1 ? b1 : b0;
                  carry_q <= 1'b0;
                  cnt_q   <= '0;
                  gnt0_q  <= pick0;
                  gnt1_q  <= pick1;
                  rr_q    <= pick0;
                  state_q <= ADD;
               end
            end
            ADD: begin
               opa_q   <= {fa_s, opa_q[5:1]};
               opb_q   <= {1'b0, opb_q[5:1]};
               carry_q <= fa_co;
               cnt_q   <= cnt_q + 3'd1;
               if (cnt_q == 3'd5) begin
                  res_q   <= {fa_co, fa_s, opa_q[5:1]};
                  bin_q   <= {fa_co, fa_s, opa_q[5:1]};
                  bcd_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= CONV;
               end
            end
            CONV: begin
               bcd_q <= bcd_shift;
               bin_q <= {bin_q[5:0], 1'b0};
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd6) begin
                  cnt_q   <= '0;
                  state_q <= SHOW;
               end
            end
            SHOW: begin
               sum_q   <= res_q;
               hex0_q  <= seg7(bcd_q[11:8]);
               hex1_q  <= seg7(bcd_q[7:4]);
               hex2_q  <= seg7(bcd_q[3:0]);
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Output mapping
   always_comb begin
      gnt0 = gnt0_q;
      gnt1 = gnt1_q;
      busy = (state_q != IDLE);
      done = done_q;
      sum  = sum_q;
      hex0 = hex0_q;
      hex1 = hex1_q;
      hex2 = hex2_q;
   end

endmodule

// File: tb/tb_serial_add_display_ctrl.sv
// Self-checking bench for serial_add_display_ctrl: arithmetic, decimal split,
// segment table and round-robin choice come from a plain reference model.
module tb_serial_add_display_ctrl;

   logic       clk = 1'b0;
   logic       rst, req0, req1;
   logic [5:0] a0, b0, a1, b1;
   logic       gnt0, gnt1, busy, done;
   logic [6:0] sum, hex0, hex1, hex2;

   int unsigned n_run  = 0;
   int unsigned n_fail = 0;
   int          last_gnt;       // requester granted last (1 after reset)
   logic [6:0]  seg_tbl [10];

   serial_add_display_ctrl dut (
      .clk  (clk),
      .rst  (rst),
      .req0 (req0),
      .a0   (a0),
      .b0   (b0),
      .req1 (req1),
      .a1   (a1),
      .b1   (b1),
      .gnt0 (gnt0),
      .gnt1 (gnt1),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .hex0 (hex0),
      .hex1 (hex1),
      .hex2 (hex2)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] exp_hex(input int unsigned s, input int unsigned pos);
      int unsigned d;
      if (pos == 0)      d = s / 100;
      else if (pos == 1) d = (s / 10) % 10;
      else               d = s % 10;
      return seg_tbl[d];
   endfunction

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic wait_grant(output logic g0, output logic g1,
                             output int unsigned waited, output bit tmo);
      g0 = 1'b0; g1 = 1'b0; waited = 0; tmo = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         waited++;
         if (gnt0 || gnt1) begin
            g0 = gnt0; g1 = gnt1; tmo = 1'b0;
            break;
         end
      end
   endtask

   // Follows one operation from its grant cycle to done; optionally
   // scrambles the granted side's operands and raises req0 mid-flight.
   task automatic observe(input int side, input bit raise0, input int unsigned raise_at,
                          output int unsigned lat, output bit tmo,
                          output bit extra, output int unsigned idle);
      lat = 0; tmo = 1'b1; extra = 1'b0; idle = 0;
      for (int unsigned i = 1; i <= 40; i++) begin
         if (side == 0) begin a0 = 6'($urandom); b0 = 6'($urandom); end
         if (side == 1) begin a1 = 6'($urandom); b1 = 6'($urandom); end
         if (raise0 && i == raise_at) req0 = 1'b1;
         tick();
         if (done) begin lat = i; tmo = 1'b0; break; end
         if (gnt0 || gnt1) extra = 1'b1;
         if (!busy) idle++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
      a0 = 6'd5; b0 = 6'd9; a1 = 6'd1; b1 = 6'd2;
      tick(); tick();
      n_run++;
      if ({gnt0, gnt1, busy, done} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {gnt0, gnt1, busy, done});
      end
      n_run++;
      if (sum !== 7'd0) begin
         n_fail++; $display("FAIL reset_sum: got %0d expected 0", sum);
      end
      n_run++;
      if ({hex0, hex1, hex2} !== {3{7'b1111111}}) begin
         n_fail++; $display("FAIL reset_hex: got %b %b %b expected all 1111111", hex0, hex1, hex2);
      end
      req0 = 1'b0; req1 = 1'b0; rst = 1'b0; last_gnt = 1;
      tick();
      n_run++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle: busy got %b expected 0", busy);
      end
   endtask

   task automatic test_zero;
      logic g0, g1; int unsigned w, lat, idle; bit tmo, extra;
      a0 = 6'd0; b0 = 6'd0; req0 = 1'b1;
      wait_grant(g0, g1, w, tmo);
      req0 = 1'b0;
      n_run++;
      if ({tmo, g0, g1} !== 3'b010 || w != 1) begin
         n_fail++; $display("FAIL zero_grant: got tmo,g0,g1=%b%b%b after %0d expected 010 after 1", tmo, g0, g1, w);
      end
      last_gnt = 0;
      observe(0, 1'b0, 0, lat, tmo, extra, idle);
      n_run++;
      if (tmo || lat != 14) begin
         n_fail++; $display("FAIL zero_latency: got %0d (timeout %0b) expected 14", lat, tmo);
      end
      n_run++;
      if (extra || idle != 0) begin
         n_fail++; $display("FAIL zero_busy_gnt: got extra=%0b idle=%0d expected 0 0", extra, idle);
      end
      n_run++;
      if (sum !== 7'd0 || {hex0, hex1, hex2} !== {3{7'b1000000}}) begin
         n_fail++; $display("FAIL zero_result: got %0d %b %b %b expected 0 1000000 x3", sum, hex0, hex1, hex2);
      end
      n_run++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL zero_done_busy: got %b expected 0", busy);
      end
      tick();
      n_run++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL done_width: got %b expected 0", done);
      end
      tick(); tick(); tick();
      n_run++;
      if (sum !== 7'd0 || hex2 !== 7'b1000000) begin
         n_fail++; $display("FAIL hold: got %0d %b expected 0 1000000", sum, hex2);
      end
   endtask

   task automatic test_max;
      logic g0, g1; int unsigned w, lat, idle; bit tmo, extra;
      a1 = 6'd63; b1 = 6'd63; req1 = 1'b1;
      wait_grant(g0, g1, w, tmo);
      req1 = 1'b0;
      n_run++;
      if ({tmo, g0, g1} !== 3'b001) begin
         n_fail++; $display("FAIL max_grant: got %b%b%b expected 001", tmo, g0, g1);
      end
      last_gnt = 1;
      observe(1, 1'b0, 0, lat, tmo, extra, idle);
      n_run++;
      if (tmo || lat != 14) begin
         n_fail++; $display("FAIL max_latency: got %0d expected 14", lat);
      end
      n_run++;
      if (sum !== 7'd126 || hex0 !== 7'b1111001 || hex1 !== 7'b0100100 || hex2 !== 7'b0000010) begin
         n_fail++; $display("FAIL max_result: got %0d %b %b %b expected 126 1111001 0100100 0000010",
                            sum, hex0, hex1, hex2);
      end
   endtask

   task automatic test_round_robin;
      logic g0, g1; int unsigned w, lat, idle; bit tmo, extra; int e;
      rst = 1'b1; tick(); rst = 1'b0; last_gnt = 1;
      a0 = 6'd48; b0 = 6'd31; a1 = 6'd32; b1 = 6'd31;
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_grant(g0, g1, w, tmo);
         e = (last_gnt == 0) ? 1 : 0;
         n_run++;
         if (tmo || g0 !== (e == 0) || g1 !== (e == 1) || w != 1) begin
            n_fail++; $display("FAIL rr_grant%0d: got g0=%b g1=%b after %0d expected requester %0d after 1",
                               k, g0, g1, w, e);
         end
         last_gnt = e;
         observe(-1, 1'b0, 0, lat, tmo, extra, idle);
         n_run++;
         if (tmo || lat != 14 || int'(sum) != ((e == 1) ? 63 : 79)) begin
            n_fail++; $display("FAIL rr_sum%0d: got %0d lat %0d expected %0d lat 14",
                               k, sum, lat, (e == 1) ? 63 : 79);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
   endtask

   task automatic test_late_request;
      logic g0, g1; int unsigned w, lat, idle; bit tmo, extra;
      int unsigned va0, vb0, va1, vb1;
      va0 = $urandom_range(0, 63); vb0 = $urandom_range(0, 63);
      va1 = $urandom_range(0, 63); vb1 = $urandom_range(0, 63);
      a0 = 6'(va0); b0 = 6'(vb0); a1 = 6'(va1); b1 = 6'(vb1);
      req1 = 1'b1;
      wait_grant(g0, g1, w, tmo);
      req1 = 1'b0;
      last_gnt = 1;
      observe(1, 1'b1, 3, lat, tmo, extra, idle);
      n_run++;
      if (tmo || extra || idle != 0 || lat != 14) begin
         n_fail++; $display("FAIL late_no_grant: got extra=%0b idle=%0d lat=%0d expected 0 0 14", extra, idle, lat);
      end
      n_run++;
      if (int'(sum) != va1 + vb1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL late_first: got %0d busy %b expected %0d busy 0", sum, busy, va1 + vb1);
      end
      wait_grant(g0, g1, w, tmo);
      req0 = 1'b0;
      n_run++;
      if (tmo || g0 !== 1'b1 || w != 1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL late_grant: got g0=%b after %0d busy %b expected 1 after 1 busy 1", g0, w, busy);
      end
      last_gnt = 0;
      observe(0, 1'b0, 0, lat, tmo, extra, idle);
      n_run++;
      if (tmo || int'(sum) != va0 + vb0) begin
         n_fail++; $display("FAIL late_second: got %0d expected %0d", sum, va0 + vb0);
      end
   endtask

   task automatic test_reset_abort;
      logic g0, g1; int unsigned w, lat, idle, ndone; bit tmo, extra;
      a0 = 6'($urandom_range(1, 63)); b0 = 6'($urandom_range(1, 63)); req0 = 1'b1;
      wait_grant(g0, g1, w, tmo);
      req0 = 1'b0;
      repeat (9) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      last_gnt = 1;
      ndone = 0;
      repeat (20) begin tick(); if (done) ndone++; end
      n_run++;
      if (ndone != 0) begin
         n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", ndone);
      end
      n_run++;
      if (sum !== 7'd0 || {hex0, hex1, hex2} !== {3{7'b1111111}}) begin
         n_fail++; $display("FAIL abort_out: got %0d %b %b %b expected 0 1111111 x3", sum, hex0, hex1, hex2);
      end
      a0 = 6'd12; b0 = 6'd48; req0 = 1'b1;
      wait_grant(g0, g1, w, tmo);
      req0 = 1'b0;
      last_gnt = 0;
      observe(0, 1'b0, 0, lat, tmo, extra, idle);
      n_run++;
      if (tmo || sum !== 7'd60 || hex0 !== 7'b1000000 || hex1 !== 7'b0000010 || hex2 !== 7'b1000000) begin
         n_fail++; $display("FAIL abort_next: got %0d %b %b %b expected 60 1000000 0000010 1000000",
                            sum, hex0, hex1, hex2);
      end
   endtask

   task automatic test_random;
      logic g0, g1; int unsigned w, lat, idle, es; bit tmo, extra; int e;
      logic [1:0] pat;
      int unsigned va0, vb0, va1, vb1;
      for (int k = 0; k < 12; k++) begin
         pat = 2'($urandom_range(1, 3));
         va0 = $urandom_range(0, 63); vb0 = $urandom_range(0, 63);
         va1 = $urandom_range(0, 63); vb1 = $urandom_range(0, 63);
         a0 = 6'(va0); b0 = 6'(vb0); a1 = 6'(va1); b1 = 6'(vb1);
         req0 = pat[0]; req1 = pat[1];
         if (pat == 2'd3) e = (last_gnt == 0) ? 1 : 0;
         else             e = (pat == 2'd1) ? 0 : 1;
         wait_grant(g0, g1, w, tmo);
         req0 = 1'b0; req1 = 1'b0;
         n_run++;
         if (tmo || g0 !== (e == 0) || g1 !== (e == 1)) begin
            n_fail++; $display("FAIL rand_grant%0d: got g0=%b g1=%b expected requester %0d (reqs %b)",
                               k, g0, g1, e, pat);
         end
         last_gnt = e;
         es = (e == 1) ? va1 + vb1 : va0 + vb0;
         observe(e, 1'b0, 0, lat, tmo, extra, idle);
         n_run++;
         if (tmo || lat != 14 || int'(sum) != es || hex0 !== exp_hex(es, 0) ||
             hex1 !== exp_hex(es, 1) || hex2 !== exp_hex(es, 2)) begin
            n_fail++; $display("FAIL rand_result%0d: got %0d %b %b %b lat %0d expected %0d %b %b %b lat 14",
                               k, sum, hex0, hex1, hex2, lat, es,
                               exp_hex(es, 0), exp_hex(es, 1), exp_hex(es, 2));
         end
      end
   endtask

   initial begin
      seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      test_reset();
      test_zero();
      test_max();
      test_round_robin();
      test_late_request();
      test_reset_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add_display_ctrl.md
SERIAL_ADD_DISPLAY_CTRL -- requirements
Module: serial_add_display_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0  input  1  requester 0 operation request, level, held until gnt0.
REQ-005 a0, b0  input  6 each  requester 0 unsigned operands.
REQ-006 req1  input  1  requester 1 operation request, level, held until gnt1.
REQ-007 a1, b1  input  6 each  requester 1 unsigned operands.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant; operands captured on that edge.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse when a new result is on sum/hex.
REQ-011 sum  output  7  last completed unsigned sum, 0..126.
REQ-012 hex0, hex1, hex2  output  7 each  active-low 7-segment codes, {g,f,e,d,c,b,a} order, for hundreds, tens and units digits of sum.

Function
REQ-013 The block SHALL use a single shared 1-bit full adder, sequenced over 6 cycles, LSB first; no parallel 6-bit adder.
REQ-014 FSM states SHALL be IDLE, ADD, CONV, SHOW; IDLE->ADD on grant; ADD->CONV after bit 5; CONV->SHOW after 7 shift steps; SHOW->IDLE unconditionally.
REQ-015 In IDLE, at a rising edge with req0 or req1 high, the block SHALL capture the granted operands and the carry-in 0, assert the matching gnt for exactly the following cycle, and enter ADD.
REQ-016 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; the pointer after reset favours requester 0.
REQ-017 A single requesting line SHALL be granted regardless of the pointer; the pointer updates on every grant.
REQ-018 Requests outside IDLE SHALL NOT be granted and SHALL remain pending; no request is dropped or queued internally.
REQ-019 ADD SHALL produce sum bit i in cycle i (i=0..5) and the final carry as bit 6 after cycle 5.
REQ-020 CONV SHALL convert the 7-bit sum to three BCD digits by double-dabble: 7 cycles, add 3 to any digit >=5 before each shift.
REQ-021 On the SHOW edge, sum and hex0..hex2 SHALL update together and done SHALL be high for exactly that following cycle.
REQ-022 Latency: done SHALL be high in the 14th cycle after the grant edge; next grant no earlier than the edge ending the done cycle; throughput 1 operation per 15 cycles.
REQ-023 Segment codes SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other digit 1111111.
REQ-024 Leading zeros SHALL be displayed (sum 7 shows 0,0,7).
REQ-025 sum and hex0..hex2 SHALL hold the last result between done pulses.
REQ-026 Operand changes after the grant edge SHALL NOT affect the operation in progress.

Reset
REQ-027 While rst is high at an edge: state IDLE, gnt0=gnt1=busy=done=0, sum=0, hex0..hex2=1111111, pointer favours requester 0.
REQ-028 rst has priority over all other inputs; reset mid-ADD or mid-CONV SHALL abort with no done pulse and no output update.

Verification
REQ-029 reset; req0, a0=0, b0=0 -> gnt0 one cycle, done 14 cycles later, sum=0, hex0=hex1=hex2=1000000.
REQ-030 req1, a1=63, b1=63 -> sum=126, hex0=1111001, hex1=0100100, hex2=0000010.
REQ-031 after reset, req0 (48+31) and req1 (32+31) raised same cycle -> gnt0 first, sum=79; then gnt1, sum=63; both still high -> grants alternate 0,1,0.
REQ-032 req0 raised in ADD cycle 2 -> no gnt until IDLE; granted on the edge ending the done cycle; busy stays 0 only in that one cycle.
REQ-033 rst pulsed in CONV cycle 3 -> no done, sum=0, hex all 1111111; subsequent 12+48 -> sum=60, hex=1000000,0000010,1000000.
REQ-034 a0 changed every cycle after gnt0 -> result equals captured a0+b0.
